// File: rtl/div_int32_issue.sv
// div_int32_issue: in-order request queue that issues one division at a time to an external divider.
// Optional macro DIV_INT32_ZERO_BYPASS_EN answers divide-by-zero locally without using the divider.
module div_int32_issue #(
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_opcode,
    input  logic [31:0]      req_dividend,
    input  logic [31:0]      req_divisor,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_quotient,
    output logic [31:0]      resp_remainder,
    output logic [TAG_W-1:0] resp_tag,
    output logic             div_en,
    output logic             div_opcode,
    output logic [31:0]      div_dividend,
    output logic [31:0]      div_divisor,
    input  logic             div_valid_out,
    input  logic [31:0]      div_quotient,
    input  logic [31:0]      div_remainder
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 65 + TAG_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_s, pop_s, full_s, empty_s;
    logic [ENTRY_W-1:0] head_s;
    logic               head_opcode_s;
    logic [31:0]        head_dividend_s, head_divisor_s;
    logic [TAG_W-1:0]   head_tag_s;

    state_t             state_q, state_d;
    logic               div_en_q, div_en_d;
    logic               op_opcode_q, op_opcode_d;
    logic [31:0]        op_dividend_q, op_dividend_d;
    logic [31:0]        op_divisor_q, op_divisor_d;
    logic [TAG_W-1:0]   op_tag_q, op_tag_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_quot_q, resp_quot_d;
    logic [31:0]        resp_rem_q, resp_rem_d;
    logic [TAG_W-1:0]   resp_tag_q, resp_tag_d;

    // Full/empty come from the registered count only, so req_ready has no input path.
    assign full_s          = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s         = (count_q == {CNT_W{1'b0}});
    assign push_s          = req_valid && !full_s;
    assign head_s          = fifo_q[rd_ptr_q];
    assign head_opcode_s   = head_s[ENTRY_W-1];
    assign head_dividend_s = head_s[ENTRY_W-2 -: 32];
    assign head_divisor_s  = head_s[TAG_W+31 -: 32];
    assign head_tag_s      = head_s[TAG_W-1:0];

    // Queue pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control FSM: pop into operand registers, pulse the divider, capture its result.
    always_comb begin
        state_d       = state_q;
        pop_s         = 1'b0;
        div_en_d      = 1'b0;
        op_opcode_d   = op_opcode_q;
        op_dividend_d = op_dividend_q;
        op_divisor_d  = op_divisor_q;
        op_tag_d      = op_tag_q;
        resp_quot_d   = resp_quot_q;
        resp_rem_d    = resp_rem_q;
        resp_tag_d    = resp_tag_q;
        if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end else begin
            resp_valid_d = resp_valid_q;
        end
        case (state_q)
            IDLE: begin
                if (!empty_s && !resp_valid_q) begin
                    pop_s         = 1'b1;
                    op_opcode_d   = head_opcode_s;
                    op_dividend_d = head_dividend_s;
                    op_divisor_d  = head_divisor_s;
                    op_tag_d      = head_tag_s;
`ifdef DIV_INT32_ZERO_BYPASS_EN
                    if (head_divisor_s == 32'd0) begin
                        resp_valid_d = 1'b1;
                        resp_quot_d  = 32'hFFFF_FFFF;
                        resp_rem_d   = head_dividend_s;
                        resp_tag_d   = head_tag_s;
                        state_d      = IDLE;
                    end else begin
                        div_en_d = 1'b1;
                        state_d  = ISSUE;
                    end
`else
                    div_en_d = 1'b1;
                    state_d  = ISSUE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (div_valid_out) begin
                    resp_valid_d = 1'b1;
                    resp_quot_d  = div_quotient;
                    resp_rem_d   = div_remainder;
                    resp_tag_d   = op_tag_q;
                    state_d      = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Queue storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= {req_opcode, req_dividend, req_divisor, req_tag};
        end
    end

    // State, operand and response registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            state_q       <= IDLE;
            div_en_q      <= 1'b0;
            op_opcode_q   <= 1'b0;
            op_dividend_q <= 32'd0;
            op_divisor_q  <= 32'd0;
            op_tag_q      <= {TAG_W{1'b0}};
            resp_valid_q  <= 1'b0;
            resp_quot_q   <= 32'd0;
            resp_rem_q    <= 32'd0;
            resp_tag_q    <= {TAG_W{1'b0}};
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            div_en_q      <= div_en_d;
            op_opcode_q   <= op_opcode_d;
            op_dividend_q <= op_dividend_d;
            op_divisor_q  <= op_divisor_d;
            op_tag_q      <= op_tag_d;
            resp_valid_q  <= resp_valid_d;
            resp_quot_q   <= resp_quot_d;
            resp_rem_q    <= resp_rem_d;
            resp_tag_q    <= resp_tag_d;
        end
    end

    assign req_ready      = !full_s;
    assign resp_valid     = resp_valid_q;
    assign resp_quotient  = resp_quot_q;
    assign resp_remainder = resp_rem_q;
    assign resp_tag       = resp_tag_q;
    assign div_en         = div_en_q;
    assign div_opcode     = op_opcode_q;
    assign div_dividend   = op_dividend_q;
    assign div_divisor    = op_divisor_q;

endmodule
